ps2_key_decoder: RTL
====================

// Module: ps2_key_decoder
// PURPOSE
//  Successor to the plain scancode-to-ASCII table. Consumes PS/2 set-2 bytes from the
//  PS/2 receiver and tracks make/break (F0) and extended (E0) prefixes, Shift and Caps Lock.
//  Emits case-correct ASCII through a valid/ready FIFO and keeps a key-press counter for the
//  seven-segment display. Sits between the PS/2 receiver and the display/console logic.
// PARAMETERS
//  FIFO_DEPTH  8  ASCII output FIFO entries; power of 2, >= 2
//  CNT_W       8  width of press_count
//  REPEAT_EN   1  1: typematic repeats of a held key push ASCII again; 0: suppressed
// PORTS
//  clk          in   1      system clock
//  rst          in   1      asynchronous reset, active-high
//  code_valid   in   1      one-cycle pulse: code holds a new scancode byte
//  code         in   8      PS/2 set-2 scancode byte
//  ascii_valid  out  1      FIFO non-empty
//  ascii_ready  in   1      consumer accepts head entry this cycle
//  ascii        out  8      FIFO head; 8'h00 when empty
//  shift_active out  1      left (12) or right (59) Shift held
//  caps_lock    out  1      Caps Lock toggle state
//  press_count  out  CNT_W  count of new (non-repeat) make events on any key, wraps to 0
//  overflow     out  1      sticky: a translated char was dropped on a full FIFO
// BEHAVIOUR
//  Reset (async, any time, including mid-prefix): FSM=IDLE, FIFO empty, ascii_valid=0,
//   ascii=0, shift_active=0, caps_lock=0, press_count=0, overflow=0, held_code=0.
//  FSM, advanced only on code_valid:
//   IDLE: F0->BRK; E0->EXT; else make event on code.
//   BRK: release of code: clear matching shift_l/shift_r; if code==held_code clear held_code; ->IDLE.
//   EXT: F0->EXT_BRK; else extended make, no ASCII, no count; ->IDLE.
//   EXT_BRK: extended release, ignored; ->IDLE.
//  Make event: repeat = (code==held_code). If !repeat: press_count++ and held_code=code.
//   Shift codes set shift_l/r, no ASCII. 58 toggles caps_lock only when !repeat, no ASCII.
//   Otherwise translate; push if result !=0 and (!repeat or REPEAT_EN).
//  Translation: letters -> lower, upper when shift_active XOR caps_lock.
//   Digits 0-9 -> '0'-'9'; with Shift -> ")!@#$%^&*(" respectively (caps ignored).
//   29->20 (space), 5A->0D, 66->08; any other code -> 00 (not pushed).
//  Latency: push in cycle of code_valid; ascii_valid visible next cycle.
//  FIFO: pop when ascii_valid && ascii_ready. Full+push without pop: drop, set overflow.
//   Full+push+pop same cycle: both succeed, no drop. Pointers wrap modulo FIFO_DEPTH.
//   Empty: ascii_ready ignored. overflow cleared only by rst.
//  code_valid in consecutive cycles is legal; each byte is processed.
// STRUCTURE
//  ps2_pkg: scancode constants (F0, E0, 12, 59, 58, 29, 5A, 66), FSM state enum.
//  Sub-module ps2_scan2ascii: combinational table (code, shift, caps) -> ascii.
//  FSM, shift/caps/held regs, counter and FIFO stay in this module.
// TESTING
//  1C, F0 1C -> one entry 61; press_count=1; ascii_valid low again after pop.
//  12, 1C, F0 1C, F0 12 -> entry 41; shift_active 1 then 0; press_count=2.
//  58, F0 58, 1C, 12, 1C -> caps_lock=1; entries 41 then 61 (Shift+Caps cancel).
//  1C 1C 1C, F0 1C, REPEAT_EN=1 -> three 61 entries, press_count=1; REPEAT_EN=0 -> one entry.
//  ascii_ready=0, FIFO_DEPTH+1 distinct keys -> FIFO full, last dropped, overflow=1;
//   repeat with ascii_ready=1 on full -> no drop.
//  E0 75, E0 F0 75, then rst asserted mid F0 prefix -> no ASCII, press_count=0, all outputs reset.

Source files
------------

// File: rtl/ps2_pkg.sv
// PS/2 set-2 scancode constants and decoder FSM state type.
// Shared by the key decoder and its translation table.
package ps2_pkg;

   localparam logic [7:0] SC_BRK    = 8'hF0;
   localparam logic [7:0] SC_EXT    = 8'hE0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;

   localparam logic [7:0] ASC_SPACE = 8'h20;
   localparam logic [7:0] ASC_CR    = 8'h0D;
   localparam logic [7:0] ASC_BS    = 8'h08;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BRK,
      ST_EXT,
      ST_EXT_BRK
   } state_t;

endpackage

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scancode to ASCII table.
// Letters follow shift XOR caps; digits follow shift only.
module ps2_scan2ascii
   import ps2_pkg::*;
(
   input  logic [7:0] i_code,
   input  logic       i_shift,
   input  logic       i_caps,
   output logic [7:0] o_ascii
);

   logic [7:0] w_lower;
   logic [7:0] w_digit;
   logic [7:0] w_sym;

   // look up the base character classes for the scancode
   always_comb begin
      w_lower = 8'h00;
      w_digit = 8'h00;
      w_sym   = 8'h00;
      case (i_code)
         8'h1C: w_lower = 8'h61;
         8'h32: w_lower = 8'h62;
         8'h21: w_lower = 8'h63;
         8'h23: w_lower = 8'h64;
         8'h24: w_lower = 8'h65;
         8'h2B: w_lower = 8'h66;
         8'h34: w_lower = 8'h67;
         8'h33: w_lower = 8'h68;
         8'h43: w_lower = 8'h69;
         8'h3B: w_lower = 8'h6A;
         8'h42: w_lower = 8'h6B;
         8'h4B: w_lower = 8'h6C;
         8'h3A: w_lower = 8'h6D;
         8'h31: w_lower = 8'h6E;
         8'h44: w_lower = 8'h6F;
         8'h4D: w_lower = 8'h70;
         8'h15: w_lower = 8'h71;
         8'h2D: w_lower = 8'h72;
         8'h1B: w_lower = 8'h73;
         8'h2C: w_lower = 8'h74;
         8'h3C: w_lower = 8'h75;
         8'h2A: w_lower = 8'h76;
         8'h1D: w_lower = 8'h77;
         8'h22: w_lower = 8'h78;
         8'h35: w_lower = 8'h79;
         8'h1A: w_lower = 8'h7A;
         8'h45: begin w_digit = 8'h30; w_sym = 8'h29; end
         8'h16: begin w_digit = 8'h31; w_sym = 8'h21; end
         8'h1E: begin w_digit = 8'h32; w_sym = 8'h40; end
         8'h26: begin w_digit = 8'h33; w_sym = 8'h23; end
         8'h25: begin w_digit = 8'h34; w_sym = 8'h24; end
         8'h2E: begin w_digit = 8'h35; w_sym = 8'h25; end
         8'h36: begin w_digit = 8'h36; w_sym = 8'h5E; end
         8'h3D: begin w_digit = 8'h37; w_sym = 8'h26; end
         8'h3E: begin w_digit = 8'h38; w_sym = 8'h2A; end
         8'h46: begin w_digit = 8'h39; w_sym = 8'h28; end
         default: ;
      endcase
   end

   // apply modifiers; control keys map directly, anything else is 00
   always_comb begin
      o_ascii = 8'h00;
      if (w_lower != 8'h00) begin
         o_ascii = (i_shift ^ i_caps) ? (w_lower - 8'h20) : w_lower;
      end else if (w_digit != 8'h00) begin
         o_ascii = i_shift ? w_sym : w_digit;
      end else begin
         case (i_code)
            SC_SPACE: o_ascii = ASC_SPACE;
            SC_ENTER: o_ascii = ASC_CR;
            SC_BKSP:  o_ascii = ASC_BS;
            default:  o_ascii = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: prefix FSM, Shift/Caps tracking,
// press counter and an ASCII output FIFO with valid/ready.
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CNT_W      = 8,
   parameter bit REPEAT_EN  = 1'b1
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             code_valid,
   input  logic [7:0]       code,
   output logic             ascii_valid,
   input  logic             ascii_ready,
   output logic [7:0]       ascii,
   output logic             shift_active,
   output logic             caps_lock,
   output logic [CNT_W-1:0] press_count,
   output logic             overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] LP_FULL = (AW+1)'(FIFO_DEPTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_shift_l;
   logic             r_shift_r;
   logic             r_caps;
   logic [7:0]       r_held;
   logic [CNT_W-1:0] r_count;
   logic             r_ovf;
   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [AW:0]      r_fill;

   logic             w_make;
   logic             w_rel;
   logic             w_repeat;
   logic             w_new;
   logic             w_is_shift;
   logic             w_is_caps;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_wr_en;
   logic [7:0]       w_xlat;

   ps2_scan2ascii u_xlat (
      .i_code  (code),
      .i_shift (shift_active),
      .i_caps  (r_caps),
      .o_ascii (w_xlat)
   );

   // prefix state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // prefix decode: classify each byte as make, release or prefix
   always_comb begin
      w_state_nxt = r_state;
      w_make      = 1'b0;
      w_rel       = 1'b0;
      if (code_valid) begin
         unique case (r_state)
            ST_IDLE: begin
               if (code == SC_BRK)      w_state_nxt = ST_BRK;
               else if (code == SC_EXT) w_state_nxt = ST_EXT;
               else                     w_make = 1'b1;
            end
            ST_BRK: begin
               w_rel       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
            ST_EXT: begin
               w_state_nxt = (code == SC_BRK) ? ST_EXT_BRK : ST_IDLE;
            end
            ST_EXT_BRK: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign w_repeat   = (code == r_held);
   assign w_new      = w_make & ~w_repeat;
   assign w_is_shift = (code == SC_LSHIFT) | (code == SC_RSHIFT);
   assign w_is_caps  = (code == SC_CAPS);
   assign w_push     = w_make & ~w_is_shift & ~w_is_caps &
                       (w_xlat != 8'h00) & (~w_repeat | REPEAT_EN);

   assign w_empty = (r_fill == '0);
   assign w_full  = (r_fill == LP_FULL);
   assign w_pop   = ~w_empty & ascii_ready;
   assign w_wr_en = w_push & (~w_full | w_pop);

   // modifier, held-key and press-count tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shift_l <= 1'b0;
         r_shift_r <= 1'b0;
         r_caps    <= 1'b0;
         r_held    <= 8'h00;
         r_count   <= '0;
      end else begin
         if (w_make && code == SC_LSHIFT) r_shift_l <= 1'b1;
         if (w_rel  && code == SC_LSHIFT) r_shift_l <= 1'b0;
         if (w_make && code == SC_RSHIFT) r_shift_r <= 1'b1;
         if (w_rel  && code == SC_RSHIFT) r_shift_r <= 1'b0;
         if (w_new && w_is_caps) r_caps <= ~r_caps;
         if (w_new) begin
            r_held  <= code;
            r_count <= r_count + CNT_W'(1);
         end else if (w_rel && code == r_held) begin
            r_held <= 8'h00;
         end
      end
   end

   // FIFO pointers, fill level and sticky drop flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_fill <= '0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_wr_en) r_wr <= r_wr + AW'(1);
         if (w_pop)   r_rd <= r_rd + AW'(1);
         r_fill <= r_fill + (AW+1)'(w_wr_en) - (AW+1)'(w_pop);
         if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      end
   end

   // FIFO storage; contents are masked by the fill level
   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wr] <= w_xlat;
   end

   assign ascii_valid  = ~w_empty;
   assign ascii        = w_empty ? 8'h00 : r_mem[r_rd];
   assign shift_active = r_shift_l | r_shift_r;
   assign caps_lock    = r_caps;
   assign press_count  = r_count;
   assign overflow     = r_ovf;

endmodule
